// File: rtl/disp_pkg.sv
// Shared constants for the multiplexed distance display: active-low segment
// patterns (bit 0 = a, bit 6 = g), FSM state types and small helpers.
package disp_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic {
        SCAN_IDLE,
        SCAN_RUN
    } scan_state_t;

    typedef enum logic [1:0] {
        CONV_IDLE,
        CONV_SHIFT,
        CONV_DONE
    } conv_state_t;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// Only the low NUM_DIGITS digits are kept; overflow is judged on the binary value.
//   state      | meaning
//   CONV_IDLE  | waiting for start
//   CONV_SHIFT | DATA_W shift-add-3 iterations, busy high
//   CONV_DONE  | commit cycle, done high, busy low, new start accepted
module bin2bcd_seq
    import disp_pkg::*;
#(
    parameter int DATA_W     = 33,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_W-1:0]       bin,
    output logic                    busy,
    output logic                    done,
    output logic [DATA_W-1:0]       value,
    output logic [NUM_DIGITS*4-1:0] bcd
);
    localparam int BW    = NUM_DIGITS * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);

    conv_state_t       state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  cnt;
    logic [BW-1:0]     adj;

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CONV_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
            value <= '0;
            bcd   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                CONV_SHIFT: begin
                    bcd   <= {adj[BW-2:0], shreg[DATA_W-1]};
                    shreg <= shreg << 1;
                    if (cnt == '0) begin
                        state <= CONV_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    // The top samples bcd/value at this same edge, before they reload.
                    if (start) begin
                        value <= bin;
                        shreg <= bin;
                        bcd   <= '0;
                        cnt   <= CNT_W'(DATA_W - 1);
                        busy  <= 1'b1;
                        state <= CONV_SHIFT;
                    end else begin
                        state <= CONV_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/distance_display_mux.sv
// Distance display: converts a binary value to BCD, scans it over multiplexed
// 7-segment digits and drives an alarm LED and a hysteretic servo output.
//   state     | meaning
//   SCAN_IDLE | just out of reset, refresh counter held at 0 on digit 0
//   SCAN_RUN  | refresh counter running, digit index advances on terminal count
module distance_display_mux
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int DATA_W      = 33,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1,
    parameter int CLOSE_TH    = 10,
    parameter int HYST        = 2,
    parameter int ALARM_MIN   = 100,
    parameter int ALARM_MAX   = 199
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     distance,
    input  logic                  distance_valid,
    output logic                  busy,
    output logic [6:0]            sseg,
    output logic [NUM_DIGITS-1:0] anodos,
    output logic                  led,
    output logic                  outservo
);
    localparam int BW    = NUM_DIGITS * 4;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [63:0] LIMIT    = pow10(NUM_DIGITS);
    localparam logic [63:0] CLOSE_LO = 64'(CLOSE_TH);
    localparam logic [63:0] OPEN_HI  = 64'(CLOSE_TH + HYST);
    localparam logic [63:0] A_MIN    = 64'(ALARM_MIN);
    localparam logic [63:0] A_MAX    = 64'(ALARM_MAX);

    logic              conv_done;
    logic [DATA_W-1:0] conv_value;
    logic [BW-1:0]     conv_bcd;

    bin2bcd_seq #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (distance_valid & ~busy),
        .bin   (distance),
        .busy  (busy),
        .done  (conv_done),
        .value (conv_value),
        .bcd   (conv_bcd)
    );

    scan_state_t           scan_state;
    logic [RC_W-1:0]       rcnt;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [BW-1:0]         digits, digits_nxt;
    logic                  ovf, ovf_nxt, new_ovf, rc_tc, all_zero, blank_cur;
    logic [63:0]           value_ext;
    logic [NUM_DIGITS-1:0] blank, sel_nxt;
    logic [3:0]            cur;
    logic [6:0]            seg_nxt;

    assign value_ext = 64'(conv_value);
    assign new_ovf   = value_ext >= LIMIT;
    assign rc_tc     = (scan_state == SCAN_RUN) && (rcnt == RC_W'(REFRESH_DIV - 1));

    // Outputs are registered from next-state values so digits, sseg and anodos
    // all change on the same edge, including the commit edge.
    always_comb begin
        digits_nxt = conv_done ? conv_bcd : digits;
        ovf_nxt    = conv_done ? new_ovf : ovf;
        idx_nxt    = idx;
        if (rc_tc) idx_nxt = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        sel_nxt    = NUM_DIGITS'(1) << idx_nxt;
        all_zero   = 1'b1;
        blank      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (digits_nxt[4*i +: 4] == 4'd0);
            blank[i] = all_zero && (i != 0) && (BLANK_LZ != 0);
        end
        blank_cur = |(blank & sel_nxt);
        cur       = 4'(digits_nxt >> (4 * int'(idx_nxt)));
        if (ovf_nxt)        seg_nxt = SEG_DASH;
        else if (blank_cur) seg_nxt = SEG_BLANK;
        else                seg_nxt = seg_digit(cur);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_state <= SCAN_IDLE;
            rcnt       <= '0;
            idx        <= '0;
            digits     <= '0;
            ovf        <= 1'b0;
            sseg       <= SEG_BLANK;
            anodos     <= '1;
            led        <= 1'b1;
            outservo   <= 1'b1;
        end else begin
            scan_state <= SCAN_RUN;
            if (scan_state == SCAN_RUN) rcnt <= rc_tc ? '0 : rcnt + 1'b1;
            idx    <= idx_nxt;
            sseg   <= seg_nxt;
            anodos <= ~sel_nxt;
            if (conv_done) begin
                digits <= conv_bcd;
                ovf    <= new_ovf;
                led    <= ~(!new_ovf && value_ext >= A_MIN && value_ext <= A_MAX);
                if (new_ovf)                outservo <= 1'b1;
                else if (value_ext < CLOSE_LO) outservo <= 1'b0;
                else if (value_ext >= OPEN_HI) outservo <= 1'b1;
            end
        end
    end

endmodule

// File: doc/distance_display_mux.md
DISTANCE_DISPLAY_MUX -- requirements
Module: distance_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 6, number of multiplexed 7-segment digits (1..8).
REQ-002 Parameter DATA_W, default 33, width of the binary input value.
REQ-003 Parameter REFRESH_DIV, default 50000, clk cycles per digit slot (>=DATA_W+4).
REQ-004 Parameter BLANK_LZ, default 1, 1 = blank leading zeros.
REQ-005 Parameter CLOSE_TH, default 10, servo closes when value < CLOSE_TH.
REQ-006 Parameter HYST, default 2, servo reopens only when value >= CLOSE_TH+HYST.
REQ-007 Parameters ALARM_MIN/ALARM_MAX, default 100/199, LED alarm window, inclusive.
REQ-008 clk  in  1  system clock; single clock domain.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 distance  in  DATA_W  unsigned binary value to display.
REQ-011 distance_valid  in  1  one-cycle strobe: sample distance.
REQ-012 busy  out  1  high while a conversion is in progress.
REQ-013 sseg  out  7  segments a..g, active-low, index 0 = a.
REQ-014 anodos  out  NUM_DIGITS  digit enables, active-low, bit 0 = least significant digit.
REQ-015 led  out  1  alarm, active-low (0 = value inside alarm window).
REQ-016 outservo  out  1  1 = open, 0 = closed.

Function
REQ-017 On distance_valid with busy=0, distance SHALL be captured and a sequential shift-add-3 binary-to-BCD conversion started; busy rises the next cycle.
REQ-018 Conversion SHALL take exactly DATA_W cycles plus one commit cycle; busy falls in the commit cycle.
REQ-019 distance_valid while busy=1 SHALL be ignored; the in-flight conversion completes unchanged.
REQ-020 Displayed digits, led and outservo SHALL update atomically in the commit cycle only; between commits they hold the last committed value.
REQ-021 If value >= 10^NUM_DIGITS, all digits SHALL show dash (segment g only) and an internal overflow flag SHALL be committed.
REQ-022 Scan FSM: a REFRESH_DIV counter advances digit index 0..NUM_DIGITS-1, wrapping to 0; exactly one anodos bit low at any time after reset.
REQ-023 sseg and anodos SHALL change in the same cycle (no ghosting cycle with stale pattern on new digit).
REQ-024 With BLANK_LZ=1, zero digits above the most significant nonzero digit SHALL be blank (sseg all 1); digit 0 is never blanked (value 0 shows "0").
REQ-025 Digits 0..9 SHALL use standard 7-segment patterns; no hex digits are produced.
REQ-026 led SHALL be 0 iff ALARM_MIN <= value <= ALARM_MAX and not overflow.
REQ-027 outservo SHALL go 0 when value < CLOSE_TH, go 1 when value >= CLOSE_TH+HYST, else hold; overflow counts as open.
REQ-028 Threshold comparisons SHALL use the full captured binary value, not decoded digits.

Reset
REQ-029 In rst cycle: busy=0, scan index=0, refresh counter=0, committed value=0, sseg=7'b1111111, anodos=all 1, led=1, outservo=1.
REQ-030 rst asserted mid-conversion SHALL abort it; no commit follows.
REQ-031 First cycle after rst: scan resumes at digit 0, displaying "0".

Structure
REQ-032 Package disp_pkg SHALL hold segment pattern constants (digits 0..9, BLANK, DASH) and the scan-state enum.
REQ-033 One sub-module bin2bcd_seq (start/busy/done, DATA_W and NUM_DIGITS parameters) SHALL implement REQ-017/018; scanning and thresholds stay in the top.

Verification
REQ-034 distance=1234 strobe, NUM_DIGITS=6 -> busy 33 cycles, then digits "1234" with upper two blank, led=1, outservo=1.
REQ-035 Sequence 12, 9, 11, 12 -> outservo 1, 0, 0 (hysteresis hold), 1.
REQ-036 distance=150 -> led=0; distance=200 -> led=1; distance=99 -> led=1.
REQ-037 distance=1000000 -> all six digits dash, led=1, outservo=1.
REQ-038 Strobe 555 then 777 two cycles later, then rst 10 cycles into a new 42 conversion -> shows 555, 777 ignored; after rst shows "0", anodos=111110 first digit slot.
REQ-039 REFRESH_DIV=4: anodos cycles 111110->111101->...->011111->111110 every 4 clocks, one-hot low, sseg changes in the same cycle as anodos.
